weight_loader: RTL and testbench
================================

Name: weight_loader

Overview:
- Write side of the layer weight store: accepts a serial stream of 8-bit weights on a valid/ready handshake and writes them into an internal N-entry weight RAM at sequential addresses.
- Exposes the same combinational read port as the existing weight ROM (32-bit select in, 8-bit weight out), so neuron datapaths read from it unchanged.
- Sits between the host/test loader and the neuron array; replaces the fixed initial-block weight tables once loaded.

Parameters:
- N, 10, number of weight entries (addresses 0..N-1).
- WEIGHT_W, 8, weight width in bits.

Ports:
- clk  input  1  system clock, rising edge.
- rst  input  1  asynchronous, active-high reset.
- start  input  1  single-cycle pulse; begins a load sequence when in IDLE or DONE.
- in_valid  input  1  in_data holds a valid weight.
- in_data  input  WEIGHT_W  weight byte, loaded in address order.
- in_ready  output  1  loader can accept a weight this cycle.
- busy  output  1  load in progress.
- done  output  1  all N weights loaded; held until next start.
- load_count  output  32  number of weights accepted in the current load.
- input_sel  input  32  read address.
- result  output  WEIGHT_W  weight at input_sel, combinational.

Behaviour:
- Reset (async, rst=1):
  - State goes to IDLE.
  - in_ready=0, busy=0, done=0, load_count=0.
  - RAM contents are not cleared.
- FSM states: IDLE, LOAD, DONE (plus CHECK when the optional feature is enabled).
- IDLE:
  - start=1 goes to LOAD and clears load_count to 0.
  - in_valid is ignored; in_ready=0.
- LOAD:
  - in_ready=1 and busy=1.
  - A transfer happens on in_valid && in_ready at a rising edge: mem[load_count] <= in_data, then load_count increments.
  - When the transfer at load_count==N-1 completes, go to DONE (or CHECK) on the same edge; in_ready drops in the next cycle.
  - in_valid=0 stalls with no state change; there is no timeout.
  - start during LOAD is ignored.
- DONE:
  - done=1, busy=0, in_ready=0.
  - load_count holds N.
  - start=1 goes to LOAD, clears done and clears load_count in the same edge.
- Read port:
  - result = mem[input_sel] when input_sel < N; otherwise result = 0.
  - A write accepted at edge k is visible on result from edge k onward, i.e. one cycle after the data is presented.
  - Reads during LOAD return current contents, which may be a mix of old and new weights.
- Boundaries:
  - N=1: a single transfer goes straight to DONE.
  - load_count never exceeds N; no write is ever issued to an address >= N.
  - Reset asserted mid-load aborts the load: already-written entries keep their new values, the rest keep their old values, and done=0.
  - Simultaneous start and in_valid in IDLE: only the state change occurs; the data is not written.

Optional Feature:
- Macro: WEIGHT_CHECKSUM_EN.
- Defined:
  - After the Nth weight, the FSM enters CHECK with in_ready=1 and accepts one more byte as a checksum.
  - The checksum is compared against the modulo-256 sum of the N loaded weights (low WEIGHT_W bits).
  - Adds output port chk_err (1 bit, reset 0), set on mismatch and cleared on start.
  - CHECK goes to DONE on the checksum transfer; done asserts regardless of mismatch.
- Not defined: no CHECK state and no chk_err port; the FSM goes from LOAD directly to DONE.

Decomposition:
- Package weight_pkg:
  - State enum encoding: IDLE=2'd0, LOAD=2'd1, CHECK=2'd2, DONE=2'd3.
  - WEIGHT_W default.
  - ADDR_W=32.
- Sub-module weight_ram:
  - N x WEIGHT_W storage.
  - Synchronous write port (we, waddr, wdata).
  - Combinational read with out-of-range return of 0.
  - No reset.
- FSM and counter stay in weight_loader.

Test Plan:
- Reset then idle: assert rst mid-cycle -> in_ready=0, busy=0, done=0, load_count=0 immediately, without waiting for a clock edge.
- Full load, N=10: start, then stream 8'h00..8'h09 with in_valid held at 1 -> ten transfers in ten cycles, done=1 on the cycle after the 10th transfer, result at input_sel=7 is 8'h07, and input_sel=10 gives 0.
- Backpressure/stall: toggle in_valid 1,0,0,1,... over a load -> exactly N writes, load_count tracks accepted transfers only, contents are 0x10..0x19 in order.
- Reset mid-load: after 4 transfers of 8'hAA, assert rst -> done=0, state IDLE; entries 0..3 read 8'hAA and entries 4..9 keep their prior values; a new start reloads cleanly.
- Reload and ignored start: start pulsed during LOAD has no effect; start in DONE clears done and a second load of 8'h55 overwrites every entry.
- With WEIGHT_CHECKSUM_EN: load 1..10 then checksum 8'h37 -> chk_err=0; repeat with 8'h36 -> chk_err=1 and done=1.

Source files
------------

// File: rtl/weight_pkg.sv
// -----------------------------------------------------------------------------
// weight_pkg
// Shared types and constants for the weight store write side.
//   state_t          loader FSM state encoding
//   DEFAULT_WEIGHT_W default weight width in bits
//   ADDR_W           width of read/write addresses and of load_count
//   accepts_start()  true in the states where a start pulse begins a load
// -----------------------------------------------------------------------------
package weight_pkg;

    localparam int DEFAULT_WEIGHT_W = 8;
    localparam int ADDR_W           = 32;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_LOAD  = 2'd1,
        ST_CHECK = 2'd2,
        ST_DONE  = 2'd3
    } state_t;

    // A load may only be (re)started from a quiescent state; start is
    // deliberately ignored while a load or checksum transfer is pending.
    function automatic logic accepts_start(input state_t s);
        return (s == ST_IDLE) || (s == ST_DONE);
    endfunction

endpackage

// File: rtl/weight_ram.sv
// -----------------------------------------------------------------------------
// weight_ram
// N x WEIGHT_W weight storage with one synchronous write port and one
// combinational read port. No reset: contents survive rst so a partial load
// leaves the untouched entries intact.
//   clk    in   write clock, rising edge
//   we     in   write enable
//   waddr  in   write address; writes at or above N are dropped
//   wdata  in   write data
//   raddr  in   read address
//   rdata  out  mem[raddr] when raddr < N, otherwise 0
// -----------------------------------------------------------------------------
module weight_ram
    import weight_pkg::*;
#(
    parameter int N        = 10,
    parameter int WEIGHT_W = DEFAULT_WEIGHT_W
) (
    input  logic                clk,
    input  logic                we,
    input  logic [ADDR_W-1:0]   waddr,
    input  logic [WEIGHT_W-1:0] wdata,
    input  logic [ADDR_W-1:0]   raddr,
    output logic [WEIGHT_W-1:0] rdata
);

    localparam int IDX_W = (N > 1) ? $clog2(N) : 1;

    logic [WEIGHT_W-1:0] mem [0:N-1];
    logic                waddr_ok;
    logic                raddr_ok;

    assign waddr_ok = (waddr < ADDR_W'(N));
    assign raddr_ok = (raddr < ADDR_W'(N));

    always_ff @(posedge clk) begin
        if (we && waddr_ok) begin
            mem[waddr[IDX_W-1:0]] <= wdata;
        end
    end

    // Out-of-range selects read as zero, matching the fixed ROM it replaces.
    always_comb begin
        rdata = '0;
        if (raddr_ok) begin
            rdata = mem[raddr[IDX_W-1:0]];
        end
    end

endmodule

// File: rtl/weight_loader.sv
// -----------------------------------------------------------------------------
// weight_loader
// Loads a serial stream of weights (valid/ready) into an internal weight RAM
// at sequential addresses 0..N-1, and exposes the ROM-compatible read port.
//
// Optional feature macro: WEIGHT_CHECKSUM_EN
//   When defined, one extra byte is accepted after the Nth weight and compared
//   against the modulo-2^WEIGHT_W sum of the loaded weights; chk_err reports a
//   mismatch. When undefined, there is no CHECK state and no chk_err port.
//
// Ports
//   clk         in   system clock, rising edge
//   rst         in   asynchronous active-high reset
//   start       in   one-cycle pulse, starts a load from IDLE or DONE
//   in_valid    in   in_data holds a weight
//   in_data     in   weight, presented in address order
//   in_ready    out  a weight (or checksum) is accepted this cycle if valid
//   busy        out  load in progress
//   done        out  all N weights loaded; held until the next start
//   load_count  out  number of weights accepted in the current load
//   input_sel   in   read address
//   result      out  weight at input_sel (0 when out of range), combinational
//   chk_err     out  checksum mismatch (only with WEIGHT_CHECKSUM_EN)
//
// States
//   state    | meaning
//   ---------+------------------------------------------------------------
//   ST_IDLE  | after reset; waiting for start, in_valid ignored
//   ST_LOAD  | accepting weights, one per in_valid cycle
//   ST_CHECK | accepting the trailing checksum byte (checksum build only)
//   ST_DONE  | all weights written; waiting for a restart
// -----------------------------------------------------------------------------
module weight_loader
    import weight_pkg::*;
#(
    parameter int N        = 10,
    parameter int WEIGHT_W = DEFAULT_WEIGHT_W
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                start,
    input  logic                in_valid,
    input  logic [WEIGHT_W-1:0] in_data,
    output logic                in_ready,
    output logic                busy,
    output logic                done,
    output logic [ADDR_W-1:0]   load_count,
    input  logic [ADDR_W-1:0]   input_sel,
    output logic [WEIGHT_W-1:0] result
`ifdef WEIGHT_CHECKSUM_EN
    ,
    output logic                chk_err
`endif
);

    state_t state;
    state_t state_nxt;

    logic   restart;
    logic   wr_en;
    logic   last_word;

    // start only counts in IDLE/DONE; the same qualified pulse clears the
    // counter (and the checksum state) so they restart with the FSM.
    assign restart   = start && accepts_start(state);
    assign wr_en     = in_valid && (state == ST_LOAD);
    assign last_word = (load_count == ADDR_W'(N - 1));

    // -------------------------------------------------------------------------
    // State register
    // -------------------------------------------------------------------------
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= ST_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // -------------------------------------------------------------------------
    // Next-state logic
    // -------------------------------------------------------------------------
    always_comb begin
        state_nxt = state;
        case (state)
            ST_IDLE: begin
                if (start) begin
                    state_nxt = ST_LOAD;
                end
            end
            ST_LOAD: begin
                if (in_valid && last_word) begin
`ifdef WEIGHT_CHECKSUM_EN
                    state_nxt = ST_CHECK;
`else
                    state_nxt = ST_DONE;
`endif
                end
            end
            ST_CHECK: begin
`ifdef WEIGHT_CHECKSUM_EN
                if (in_valid) begin
                    state_nxt = ST_DONE;
                end
`else
                state_nxt = ST_IDLE;
`endif
            end
            ST_DONE: begin
                if (start) begin
                    state_nxt = ST_LOAD;
                end
            end
            default: state_nxt = ST_IDLE;
        endcase
    end

    // -------------------------------------------------------------------------
    // Output decode
    // -------------------------------------------------------------------------
    always_comb begin
        in_ready = 1'b0;
        busy     = 1'b0;
        done     = 1'b0;
        case (state)
            ST_LOAD: begin
                in_ready = 1'b1;
                busy     = 1'b1;
            end
            ST_CHECK: begin
                in_ready = 1'b1;
                busy     = 1'b1;
            end
            ST_DONE: begin
                done = 1'b1;
            end
            default: ;
        endcase
    end

    // -------------------------------------------------------------------------
    // Accepted-weight counter; doubles as the RAM write address. It can only
    // increment in LOAD, and LOAD is left on the transfer at N-1, so it tops
    // out at N and holds there through CHECK/DONE.
    // -------------------------------------------------------------------------
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            load_count <= '0;
        end else if (restart) begin
            load_count <= '0;
        end else if (wr_en) begin
            load_count <= load_count + ADDR_W'(1);
        end
    end

`ifdef WEIGHT_CHECKSUM_EN
    // -------------------------------------------------------------------------
    // Running sum of the loaded weights and the checksum compare.
    // -------------------------------------------------------------------------
    logic [WEIGHT_W-1:0] sum;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sum     <= '0;
            chk_err <= 1'b0;
        end else if (restart) begin
            sum     <= '0;
            chk_err <= 1'b0;
        end else begin
            if (wr_en) begin
                sum <= sum + in_data;
            end
            if ((state == ST_CHECK) && in_valid && (in_data != sum)) begin
                chk_err <= 1'b1;
            end
        end
    end
`endif

    // -------------------------------------------------------------------------
    // Storage
    // -------------------------------------------------------------------------
    weight_ram #(
        .N        (N),
        .WEIGHT_W (WEIGHT_W)
    ) u_ram (
        .clk   (clk),
        .we    (wr_en),
        .waddr (load_count),
        .wdata (in_data),
        .raddr (input_sel),
        .rdata (result)
    );

endmodule

// File: tb/tb_weight_loader.sv
// -----------------------------------------------------------------------------
// tb_weight_loader
// Self-checking bench for weight_loader (N=10, WEIGHT_W=8). A fixed vector
// table covers the basic full load, hand-written sequences cover stall,
// mid-load reset and restart behaviour, and a randomized phase is compared
// every cycle against a behavioural model of the load protocol.
// Honours WEIGHT_CHECKSUM_EN the same way the design does.
// -----------------------------------------------------------------------------
module tb_weight_loader;

    localparam int N  = 10;
    localparam int WW = 8;
`ifdef WEIGHT_CHECKSUM_EN
    localparam bit CHK = 1'b1;
`else
    localparam bit CHK = 1'b0;
`endif

    logic          clk;
    logic          rst;
    logic          start;
    logic          in_valid;
    logic [WW-1:0] in_data;
    logic          in_ready;
    logic          busy;
    logic          done;
    logic [31:0]   load_count;
    logic [31:0]   input_sel;
    logic [WW-1:0] result;
`ifdef WEIGHT_CHECKSUM_EN
    logic          chk_err;
`endif

    weight_loader #(.N(N), .WEIGHT_W(WW)) dut (
        .clk        (clk),
        .rst        (rst),
        .start      (start),
        .in_valid   (in_valid),
        .in_data    (in_data),
        .in_ready   (in_ready),
        .busy       (busy),
        .done       (done),
        .load_count (load_count),
        .input_sel  (input_sel),
        .result     (result)
`ifdef WEIGHT_CHECKSUM_EN
        ,
        .chk_err    (chk_err)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_checks = 0;
    int n_fail   = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    // ---------------- behavioural model ----------------
    logic [WW-1:0] m_mem [N];
    bit            m_known [N];
    bit            m_load, m_check, m_done, m_err;
    int            m_cnt;
    logic [WW-1:0] m_sum;

    task automatic model_reset();
        m_load  = 0;
        m_check = 0;
        m_done  = 0;
        m_err   = 0;
        m_cnt   = 0;
        m_sum   = '0;
    endtask

    // Applies the inputs currently driven, as the next rising edge will.
    task automatic model_edge();
        if (m_load) begin
            if (in_valid) begin
                m_mem[m_cnt]   = in_data;
                m_known[m_cnt] = 1;
                m_sum          = m_sum + in_data;
                m_cnt++;
                if (m_cnt == N) begin
                    m_load = 0;
                    if (CHK) m_check = 1;
                    else     m_done  = 1;
                end
            end
        end else if (m_check) begin
            if (in_valid) begin
                if (in_data != m_sum) m_err = 1;
                m_check = 0;
                m_done  = 1;
            end
        end else if (start) begin
            m_load = 1;
            m_done = 0;
            m_err  = 0;
            m_cnt  = 0;
            m_sum  = '0;
        end
    endtask

    task automatic compare_model();
        check("in_ready", in_ready, m_load | m_check);
        check("busy", busy, m_load | m_check);
        check("done", done, m_done);
        check("load_count", load_count, m_cnt);
        if (input_sel >= N) check("result_oor", result, 0);
        else if (m_known[input_sel]) check("result", result, m_mem[input_sel]);
`ifdef WEIGHT_CHECKSUM_EN
        check("chk_err", chk_err, m_err);
`endif
    endtask

    // Called at posedge+1; inputs then hold until the next edge.
    task automatic drive(input bit s, input bit v, input logic [WW-1:0] d, input int sel);
        start     = s;
        in_valid  = v;
        in_data   = d;
        input_sel = sel;
        model_edge();
        @(posedge clk);
        #1;
        compare_model();
    endtask

    task automatic send_checksum(input logic [WW-1:0] d);
`ifdef WEIGHT_CHECKSUM_EN
        drive(0, 1, d, 0);
`endif
    endtask

    // Asynchronous reset between clock edges; called at posedge+1.
    task automatic pulse_reset();
        #3;
        rst = 1'b1;
        #1;
        model_reset();
        check("arst_in_ready", in_ready, 0);
        check("arst_busy", busy, 0);
        check("arst_done", done, 0);
        check("arst_load_count", load_count, 0);
        #1;
        rst = 1'b0;
    endtask

    // ---------------- vector table ----------------
    typedef struct {
        bit          start;
        bit          valid;
        logic [7:0]  data;
        logic [31:0] sel;
        bit          e_ready;
        bit          e_busy;
        bit          e_done;
        logic [31:0] e_count;
        logic [7:0]  e_result;
    } vec_t;

    vec_t vecs[$];

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        vec_t v;
        rst       = 1'b1;
        start     = 1'b0;
        in_valid  = 1'b0;
        in_data   = '0;
        input_sel = '0;
        for (int i = 0; i < N; i++) m_known[i] = 0;
        model_reset();

        #2;
        check("reset_in_ready", in_ready, 0);
        check("reset_busy", busy, 0);
        check("reset_done", done, 0);
        check("reset_load_count", load_count, 0);
        @(posedge clk);
        #1;
        rst = 1'b0;

        // start together with in_valid: state change only, nothing written
        vecs.push_back('{1, 1, 8'hEE, 10, 1, 1, 0, 0, 8'h00});
        for (int i = 0; i < N; i++) begin
            v = '{0, 1, 8'(i), i, (i < N - 1) || CHK, (i < N - 1) || CHK,
                  (i == N - 1) && !CHK, i + 1, 8'(i)};
            vecs.push_back(v);
        end
        // checksum build: trailing byte 0+1+...+9 = 0x2D; otherwise an idle cycle
        vecs.push_back('{0, CHK, CHK ? 8'h2D : 8'h00, 7, 0, 0, 1, N, 8'h07});
        vecs.push_back('{0, 0, 8'h00, 10, 0, 0, 1, N, 8'h00});
        vecs.push_back('{0, 0, 8'h00, 32'hFFFF_FFFF, 0, 0, 1, N, 8'h00});
        vecs.push_back('{0, 1, 8'h99, 9, 0, 0, 1, N, 8'h09});
        vecs.push_back('{0, 0, 8'h00, 0, 0, 0, 1, N, 8'h00});

        foreach (vecs[k]) begin
            start     = vecs[k].start;
            in_valid  = vecs[k].valid;
            in_data   = vecs[k].data;
            input_sel = vecs[k].sel;
            model_edge();
            @(posedge clk);
            #1;
            check($sformatf("vec%0d_in_ready", k), in_ready, vecs[k].e_ready);
            check($sformatf("vec%0d_busy", k), busy, vecs[k].e_busy);
            check($sformatf("vec%0d_done", k), done, vecs[k].e_done);
            check($sformatf("vec%0d_load_count", k), load_count, vecs[k].e_count);
            check($sformatf("vec%0d_result", k), result, vecs[k].e_result);
        end

        // ---- backpressure: in_valid 1,0,0,1,0,0,... ----
        drive(1, 0, 8'h00, 0);
        begin
            int k      = 0;
            int budget = 200;
            while (m_load && budget > 0) begin
                drive(0, (k % 3) == 0, 8'h10 + 8'(m_cnt), $urandom_range(0, 11));
                k++;
                budget--;
            end
            if (m_load) begin
                n_checks++;
                n_fail++;
                $display("FAIL stall_budget: load still running after 200 cycles, expected completion");
            end
        end
        send_checksum(m_sum);
        check("stall_done", done, 1);
        check("stall_count", load_count, N);
        for (int i = 0; i < N; i++) begin
            drive(0, 0, 8'h00, i);
            check($sformatf("stall_mem%0d", i), result, 8'h10 + 8'(i));
        end

        // ---- reset mid-load ----
        drive(1, 0, 8'h00, 0);
        for (int i = 0; i < 4; i++) drive(0, 1, 8'hAA, i);
        in_valid = 1'b0;
        pulse_reset();
        drive(0, 1, 8'h77, 0);  // IDLE ignores in_valid
        for (int i = 0; i < N; i++) begin
            drive(0, 0, 8'h00, i);
            check($sformatf("rstmid_mem%0d", i), result, (i < 4) ? 8'hAA : 8'h10 + 8'(i));
        end
        drive(1, 0, 8'h00, 0);
        for (int i = 0; i < N; i++) drive(0, 1, 8'($urandom), $urandom_range(0, 12));
        send_checksum(m_sum);
        check("reload_done", done, 1);

        // ---- start ignored in LOAD, restart from DONE ----
        drive(1, 0, 8'h00, 0);
        for (int i = 0; i < 3; i++) drive(0, 1, 8'h33, i);
        drive(1, 1, 8'h33, 0);
        check("ign_start_count", load_count, 4);
        check("ign_start_busy", busy, 1);
        while (m_load) drive(0, 1, 8'h33, 0);
        send_checksum(m_sum);
        check("ign_start_done", done, 1);
        drive(1, 0, 8'h00, 0);
        check("restart_done", done, 0);
        check("restart_count", load_count, 0);
        for (int i = 0; i < N; i++) drive(0, 1, 8'h55, 0);
        send_checksum(m_sum);
        for (int i = 0; i < N; i++) begin
            drive(0, 0, 8'h00, i);
            check($sformatf("reload55_mem%0d", i), result, 8'h55);
        end

        // ---- randomized traffic against the model ----
        for (int r = 0; r < 400; r++) begin
            if (r == 217) pulse_reset();
            drive(($urandom_range(0, 7) == 0), $urandom_range(0, 1), 8'($urandom),
                  $urandom_range(0, 13));
        end

`ifdef WEIGHT_CHECKSUM_EN
        // ---- checksum: 1..10 sums to 0x37 ----
        pulse_reset();
        drive(1, 0, 8'h00, 0);
        for (int i = 1; i <= N; i++) drive(0, 1, 8'(i), 0);
        drive(0, 1, 8'h37, 0);
        check("chk_good_err", chk_err, 0);
        check("chk_good_done", done, 1);
        drive(1, 0, 8'h00, 0);
        for (int i = 1; i <= N; i++) drive(0, 1, 8'(i), 0);
        drive(0, 1, 8'h36, 0);
        check("chk_bad_err", chk_err, 1);
        check("chk_bad_done", done, 1);
        drive(1, 0, 8'h00, 0);
        check("chk_clear_on_start", chk_err, 0);
`endif

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
